// File: rtl/crop_window_stream.sv
// Multi-channel raster crop with a per-frame shadowed window; passing beats appear 1 cycle after accept.
// One-entry output register: input stalls only while that register is full and the sink is not ready.
module crop_window_stream #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int CHANNELS        = 1,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int DEF_X1          = 10,
  parameter int DEF_Y1          = 10,
  parameter int DEF_COLS        = 20,
  parameter int DEF_ROWS        = 20,
  localparam int PW             = PIXEL_BIT_WIDTH * CHANNELS,
  localparam int XW             = $clog2(IN_COLS + 1),
  localparam int YW             = $clog2(IN_ROWS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] pixel_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [XW-1:0] cfg_x1,
  input  logic [YW-1:0] cfg_y1,
  input  logic [XW-1:0] cfg_cols,
  input  logic [YW-1:0] cfg_rows,
  output logic [PW-1:0] pixel_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eol,
  output logic          frame_done
);

  localparam logic [XW-1:0] X_LAST = XW'(IN_COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_ROWS - 1);
  localparam logic [XW:0]   X_SPAN = (XW+1)'(IN_COLS);
  localparam logic [XW:0]   X_ONE  = (XW+1)'(1);

  logic [XW-1:0] x, sh_x1, sh_cols, cx;
  logic [YW-1:0] y, sh_y1, sh_rows, cy;
  logic          sof_pending;
  logic [XW:0]   x_end, x_lim;
  logic [YW:0]   y_end;
  logic          accept, pass, last, is_eol, first;

  assign in_ready = out_ready | ~out_valid;

  always_comb begin
    accept = in_valid & in_ready;
    // in_sof forces the beat to (0,0) regardless of where the counters were
    cx     = in_sof ? '0 : x;
    cy     = in_sof ? '0 : y;
    // One extra bit keeps windows running off the frame edge from wrapping
    x_end  = {1'b0, sh_x1} + {1'b0, sh_cols};
    y_end  = {1'b0, sh_y1} + {1'b0, sh_rows};
    x_lim  = (x_end > X_SPAN) ? X_SPAN : x_end;
    pass   = (cx >= sh_x1) & ({1'b0, cx} < x_end) &
             (cy >= sh_y1) & ({1'b0, cy} < y_end);
    is_eol = ({1'b0, cx} == (x_lim - X_ONE));
    last   = (cx == X_LAST) & (cy == Y_LAST);
    first  = sof_pending | in_sof;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (cx == X_LAST) begin
        x <= '0;
        y <= (cy == Y_LAST) ? '0 : cy + YW'(1);
      end else begin
        x <= cx + XW'(1);
        y <= cy;
      end
    end
  end

  // Window config only changes at the frame boundary, so a frame is cropped consistently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x1   <= XW'(DEF_X1);
      sh_y1   <= YW'(DEF_Y1);
      sh_cols <= XW'(DEF_COLS);
      sh_rows <= YW'(DEF_ROWS);
    end else if (accept & last) begin
      sh_x1   <= cfg_x1;
      sh_y1   <= cfg_y1;
      sh_cols <= cfg_cols;
      sh_rows <= cfg_rows;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sof_pending <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= accept & last;
      if (accept) begin
        if (last)
          sof_pending <= 1'b1;
        else if (pass)
          sof_pending <= 1'b0;
        else if (in_sof)
          sof_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (accept & pass) begin
      pixel_out <= pixel_in;
      out_valid <= 1'b1;
      out_sof   <= first;
      out_eol   <= is_eol;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end
  end

endmodule
